shared_reg_arbiter: RTL
=======================

# shared_reg_arbiter

Round-robin write arbiter for a single shared enabled register (the reset-plus-enable D-register primitive, widened to WIDTH bits). N requesters contend for write access; at most one is granted per cycle and its data is loaded into the register at the next clock edge. The block sits between several producer blocks and one shared configuration/status register, and replaces ad-hoc enable muxing.

## Interface
- N, default 4: number of requesters (2..16).
- WIDTH, default 8: register data width.

- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N  per-requester write request; held until granted.
- wdata  in  N*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]; stable while req[i]=1.
- lock  in  N  per-requester lock hold (present only with SHARED_REG_ARB_LOCK_EN).
- gnt  out  N  one-hot grant, combinational, high in the cycle requester i's wdata is captured.
- q  out  WIDTH  shared register contents.
- q_owner  out  clog2(N)  index of the requester that last wrote q.
- busy  out  1  high while the FSM is in LOCKED.

## Operation
- Internal state: ptr (clog2(N) bits, round-robin start index), q, q_owner, FSM state {IDLE, LOCKED}, lock_owner.
- IDLE arbitration: search req starting at ptr, wrapping upward modulo N; first set bit wins. gnt is one-hot on the winner, all-zero if req==0.
- On grant to i: q <= wdata[i], q_owner <= i, ptr <= (i+1) mod N. Wrap: grant to N-1 sets ptr to 0.
- No request: gnt=0, q, q_owner, ptr hold (register enable low).
- gnt[i] is never high unless req[i]=1; gnt never has more than one bit set.
- Requesters treat gnt[i] as the handshake; dropping req[i] before gnt is legal (request withdrawn, nothing written).
- Reset (synchronous, overrides all): q=0, q_owner=0, ptr=0, state=IDLE, lock_owner=0. gnt is combinational from req and ptr=0, so a requester granted in the reset cycle is not written; reset wins.

## Timing
- Grant latency: 0 cycles (gnt in same cycle as req when eligible).
- Write latency: q and q_owner show new value 1 cycle after the gnt cycle.
- Fairness: with all N requesting continuously, each is granted exactly once per N cycles.
- Reset mid-operation: the cycle after reset is asserted, all state is at reset values regardless of pending req or LOCKED state.

## Configuration
- Macro SHARED_REG_ARB_LOCK_EN.
- Defined: lock port exists. If the granted requester i has lock[i]=1 in its grant cycle, state -> LOCKED, lock_owner <= i, busy=1 from next cycle. In LOCKED only req[lock_owner] is eligible; others see gnt=0 and ptr holds. Each LOCKED cycle with req[lock_owner]=1 writes q as normal. When lock[lock_owner]=0 in a LOCKED cycle: that cycle still grants only the owner, then state -> IDLE, ptr <= (lock_owner+1) mod N. lock bits of non-granted requesters are ignored.
- Undefined: no lock port, no FSM logic; busy tied 0; behaviour is pure IDLE arbitration.

## Test plan
- Reset: assert reset 2 cycles with req=4'b1111 -> q=0, q_owner=0, ptr=0 after release; first grant goes to requester 0.
- Single requester: req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100 same cycle; next cycle q=8'hA5, q_owner=2; then req=0 -> q holds 8'hA5.
- Rotation: req=4'b1111 held 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3; q tracks each wdata one cycle later.
- Wrap and skip: after grant to 3 (ptr=0), req=4'b1010 -> gnt 1, then 3, then 1.
- Lock (macro defined): requester 1 granted with lock[1]=1, req=4'b1111 for 4 cycles with lock held -> gnt=4'b0010 each cycle, busy=1; drop lock[1] -> one more grant to 1, then gnt to 2, busy=0.
- Reset mid-lock: in LOCKED with owner 1, assert reset one cycle -> busy=0, q=0, ptr=0; next grant with req=4'b1111 goes to 0.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of one shared enabled register.
// Optional lock/hold mode is built when SHARED_REG_ARB_LOCK_EN is defined.
module shared_reg_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N-1:0]           req,
   input  logic [N*WIDTH-1:0]     wdata,
`ifdef SHARED_REG_ARB_LOCK_EN
   input  logic [N-1:0]           lock,
`endif
   output logic [N-1:0]           gnt,
   output logic [WIDTH-1:0]       q,
   output logic [$clog2(N)-1:0]   q_owner,
   output logic                   busy
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] ptr;
   logic [IW-1:0] win;
   logic          hit;
   logic [IW-1:0] sel;
   logic          en;

   function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
      return (int'(i) == N - 1) ? '0 : i + 1'b1;
   endfunction

   // First requester at or above ptr, wrapping modulo N
   always_comb begin
      int j;
      win = '0;
      hit = 1'b0;
      j   = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!hit && req[j]) begin
            hit = 1'b1;
            win = IW'(j);
         end
      end
   end

`ifdef SHARED_REG_ARB_LOCK_EN
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]    state;
   logic [IW-1:0] lock_owner;
   logic          locked;

   assign locked = (state == LOCKED);
   assign sel    = locked ? lock_owner : win;
   assign en     = locked ? req[lock_owner] : hit;
   assign busy   = locked;

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr        <= '0;
         state      <= IDLE;
         lock_owner <= '0;
      end else if (locked) begin
         if (!lock[lock_owner]) begin
            state <= IDLE;
            ptr   <= inc(lock_owner);
         end
      end else if (hit) begin
         ptr <= inc(win);
         if (lock[win]) begin
            state      <= LOCKED;
            lock_owner <= win;
         end
      end
   end
`else
   assign sel  = win;
   assign en   = hit;
   assign busy = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) ptr <= '0;
      else if (hit) ptr <= inc(win);
   end
`endif

   assign gnt = en ? (N'(1) << sel) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         q       <= '0;
         q_owner <= '0;
      end else if (en) begin
         q       <= wdata[sel*WIDTH +: WIDTH];
         q_owner <= sel;
      end
   end

endmodule
